// File: rtl/pkt_buffer_writer.sv
// Packet-buffer ingress writer: binds a free ID to each packet, stores flits at {id, idx}, emits one metadata record per packet.
// Writes land one cycle after acceptance; ingress stalls while no ID is held or an undrained record would be overwritten.
`timescale 1ns/1ps

package pkt_buffer_writer_pkg;
  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
    logic [511:0] data;
  } flit_t;
endpackage

module pkt_buffer_writer
  import pkt_buffer_writer_pkg::*;
#(
  parameter int PKT_AWIDTH    = 12,
  parameter int MAX_FLITS     = 32,
  parameter int PKTBUF_AWIDTH = PKT_AWIDTH + 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic [511:0]             in_data,
  input  logic [5:0]               in_empty,
  output logic                     in_ready,
  input  logic                     emptylist_out_valid,
  input  logic [PKT_AWIDTH-1:0]    emptylist_out_data,
  output logic                     emptylist_out_ready,
  output logic                     pkt_buffer_write,
  output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
  output flit_t                    pkt_buffer_writedata,
  output logic                     meta_valid,
  output logic [PKT_AWIDTH-1:0]    meta_pktID,
  output logic [5:0]               meta_flits,
  output logic [15:0]              meta_len,
  output logic                     meta_trunc,
  input  logic                     meta_ready,
  output logic [15:0]              err_cnt
);

  typedef enum logic [1:0] {NO_ID, HAVE_ID, IN_PKT} state_e;

  state_e                   state_q, state_d;
  logic [PKT_AWIDTH-1:0]    pkt_id_q;
  logic [5:0]               flit_cnt_q, flit_cnt_d;
  logic                     trunc_q, trunc_d;
  logic                     write_q, write_d;
  logic [4:0]               flit_idx_d;
  logic [PKTBUF_AWIDTH-1:0] addr_q;
  flit_t                    wdata_q;
  logic                     meta_valid_q;
  logic [PKT_AWIDTH-1:0]    meta_pktid_q;
  logic [5:0]               meta_flits_q;
  logic [15:0]              meta_len_q, meta_len_d;
  logic                     meta_trunc_q;
  logic [15:0]              err_cnt_q;
  logic                     accept, close_pkt, err_inc, meta_free, room;

  assign meta_free = !meta_valid_q || meta_ready;
  assign accept    = in_valid && in_ready;
  assign room      = flit_cnt_q < 6'(MAX_FLITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NO_ID;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NO_ID:   if (emptylist_out_valid) state_d = HAVE_ID;
      HAVE_ID: if (accept && in_sop) state_d = in_eop ? NO_ID : IN_PKT;
      IN_PKT:  if (accept && in_eop) state_d = NO_ID;
      default: state_d = NO_ID;
    endcase
  end

  // Pop is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    in_ready            = (state_q == HAVE_ID || state_q == IN_PKT) && meta_free;
    emptylist_out_ready = rst_n && (state_q == NO_ID) && emptylist_out_valid;
  end

  always_comb begin
    write_d    = 1'b0;
    flit_idx_d = '0;
    close_pkt  = 1'b0;
    err_inc    = 1'b0;
    flit_cnt_d = flit_cnt_q;
    trunc_d    = trunc_q;
    case (state_q)
      HAVE_ID: if (accept) begin
        if (in_sop) begin
          write_d    = 1'b1;
          flit_cnt_d = 6'd1;
          trunc_d    = 1'b0;
          close_pkt  = in_eop;
        end else begin
          err_inc = 1'b1;
        end
      end
      IN_PKT: if (accept) begin
        if (room) begin
          write_d    = 1'b1;
          flit_idx_d = flit_cnt_q[4:0];
          flit_cnt_d = flit_cnt_q + 6'd1;
        end else begin
          trunc_d = 1'b1;
        end
        err_inc   = in_sop;
        close_pkt = in_eop;
      end
      default: ;
    endcase
  end

  // A truncated packet never stored its EOP flit, so its empty bytes do not apply.
  assign meta_len_d = {4'd0, flit_cnt_d, 6'd0} - {10'd0, (trunc_d ? 6'd0 : in_empty)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_id_q     <= '0;
      flit_cnt_q   <= '0;
      trunc_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      meta_valid_q <= 1'b0;
      meta_pktid_q <= '0;
      meta_flits_q <= '0;
      meta_len_q   <= '0;
      meta_trunc_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (state_q == NO_ID && emptylist_out_valid) pkt_id_q <= emptylist_out_data;
      flit_cnt_q <= flit_cnt_d;
      trunc_q    <= trunc_d;
      write_q    <= write_d;
      if (write_d) begin
        addr_q  <= {pkt_id_q, flit_idx_d};
        wdata_q <= '{sop: in_sop, eop: in_eop, empty: in_empty, data: in_data};
      end
      if (close_pkt) begin
        meta_valid_q <= 1'b1;
        meta_pktid_q <= pkt_id_q;
        meta_flits_q <= flit_cnt_d;
        meta_len_q   <= meta_len_d;
        meta_trunc_q <= trunc_d;
      end else if (meta_ready) begin
        meta_valid_q <= 1'b0;
      end
      if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_buffer_write     = write_q;
  assign pkt_buffer_address   = addr_q;
  assign pkt_buffer_writedata = wdata_q;
  assign meta_valid           = meta_valid_q;
  assign meta_pktID           = meta_pktid_q;
  assign meta_flits           = meta_flits_q;
  assign meta_len             = meta_len_q;
  assign meta_trunc           = meta_trunc_q;
  assign err_cnt              = err_cnt_q;

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// Directed vector bench for pkt_buffer_writer: table rows plus hand sequences for truncation and reset.
`timescale 1ns/1ps

module tb_pkt_buffer_writer;
  import pkt_buffer_writer_pkg::*;

  typedef struct packed {
    logic iv, sop, eop; logic [5:0] emp; logic elv; logic [11:0] eld; logic mrdy;
  } stim_t;
  typedef struct packed {
    logic rdy, elr, wr; logic [16:0] addr; logic wsop, weop; logic [5:0] wemp;
    logic mv; logic [11:0] mid; logic [5:0] mfl; logic [15:0] mlen; logic mtr; logic [15:0] err;
  } exp_t;
  typedef struct { stim_t s; exp_t e; } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_sop, in_eop, in_ready;
  logic [511:0] in_data;
  logic [5:0]   in_empty;
  logic         emptylist_out_valid, emptylist_out_ready;
  logic [11:0]  emptylist_out_data;
  logic         pkt_buffer_write;
  logic [16:0]  pkt_buffer_address;
  flit_t        pkt_buffer_writedata;
  logic         meta_valid, meta_trunc, meta_ready;
  logic [11:0]  meta_pktID;
  logic [5:0]   meta_flits;
  logic [15:0]  meta_len, err_cnt;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  pkt_buffer_writer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_empty(in_empty), .in_ready(in_ready),
    .emptylist_out_valid(emptylist_out_valid), .emptylist_out_data(emptylist_out_data),
    .emptylist_out_ready(emptylist_out_ready),
    .pkt_buffer_write(pkt_buffer_write), .pkt_buffer_address(pkt_buffer_address),
    .pkt_buffer_writedata(pkt_buffer_writedata),
    .meta_valid(meta_valid), .meta_pktID(meta_pktID), .meta_flits(meta_flits),
    .meta_len(meta_len), .meta_trunc(meta_trunc), .meta_ready(meta_ready),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mkdata(input int k);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(k);
    return {16{w}};
  endfunction

  function automatic stim_t S(input bit iv, sop, eop, input int emp, input bit elv,
                              input int eld, input bit mrdy);
    stim_t s;
    s.iv = iv; s.sop = sop; s.eop = eop; s.emp = 6'(emp);
    s.elv = elv; s.eld = 12'(eld); s.mrdy = mrdy;
    return s;
  endfunction

  function automatic exp_t E(input bit rdy, elr, wr, input int addr, input bit wsop, weop,
                             input int wemp, input bit mv, input int mid, mfl, mlen,
                             input bit mtr, input int err);
    exp_t e;
    e.rdy = rdy; e.elr = elr; e.wr = wr; e.addr = 17'(addr); e.wsop = wsop; e.weop = weop;
    e.wemp = 6'(wemp); e.mv = mv; e.mid = 12'(mid); e.mfl = 6'(mfl); e.mlen = 16'(mlen);
    e.mtr = mtr; e.err = 16'(err);
    return e;
  endfunction

  // Write and metadata fields only carry meaning while their strobes are high.
  function automatic exp_t observe();
    exp_t o;
    o = '0;
    o.rdy = in_ready; o.elr = emptylist_out_ready; o.wr = pkt_buffer_write;
    if (pkt_buffer_write) begin
      o.addr = pkt_buffer_address; o.wsop = pkt_buffer_writedata.sop;
      o.weop = pkt_buffer_writedata.eop; o.wemp = pkt_buffer_writedata.empty;
    end
    o.mv = meta_valid;
    if (meta_valid) begin
      o.mid = meta_pktID; o.mfl = meta_flits; o.mlen = meta_len; o.mtr = meta_trunc;
    end
    o.err = err_cnt;
    return o;
  endfunction

  task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s, input int k);
    in_valid = s.iv; in_sop = s.sop; in_eop = s.eop; in_empty = s.emp;
    emptylist_out_valid = s.elv; emptylist_out_data = s.eld; meta_ready = s.mrdy;
    in_data = mkdata(k);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {in_ready, emptylist_out_ready, pkt_buffer_write, pkt_buffer_address,
        meta_valid, meta_pktID, meta_flits, meta_len, meta_trunc, err_cnt}, '0);
    chk({name, "_wdata"}, pkt_buffer_writedata, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(S(1, 1, 0, 5, 1, 3, 1), 0);
    // IDs 5,6,7 queued, then 9 after an empty-list gap, then 11.
    tbl.push_back('{S(0,0,0,0, 1,5,1),  E(0,1, 0,0,0,0,0,   0,0,0,0,0,   0)});
    tbl.push_back('{S(1,1,1,10,1,6,1),  E(1,0, 0,0,0,0,0,   0,0,0,0,0,   0)});
    tbl.push_back('{S(0,0,0,0, 1,6,1),  E(0,1, 1,160,1,1,10, 1,5,1,54,0,  0)});
    tbl.push_back('{S(1,1,0,0, 1,7,1),  E(1,0, 0,0,0,0,0,   0,0,0,0,0,   0)});
    tbl.push_back('{S(1,0,1,4, 1,7,1),  E(1,0, 1,192,1,0,0,  0,0,0,0,0,   0)});
    tbl.push_back('{S(0,0,0,0, 1,7,1),  E(0,1, 1,193,0,1,4,  1,6,2,124,0, 0)});
    tbl.push_back('{S(1,1,0,0, 0,0,0),  E(1,0, 0,0,0,0,0,   0,0,0,0,0,   0)});
    tbl.push_back('{S(1,0,0,0, 0,0,0),  E(1,0, 1,224,1,0,0,  0,0,0,0,0,   0)});
    tbl.push_back('{S(1,0,1,0, 0,0,0),  E(1,0, 1,225,0,0,0,  0,0,0,0,0,   0)});
    tbl.push_back('{S(1,1,1,0, 0,0,0),  E(0,0, 1,226,0,1,0,  1,7,3,192,0, 0)});
    tbl.push_back('{S(1,1,1,0, 1,9,0),  E(0,1, 0,0,0,0,0,   1,7,3,192,0, 0)});
    tbl.push_back('{S(1,1,1,2, 0,0,0),  E(0,0, 0,0,0,0,0,   1,7,3,192,0, 0)});
    tbl.push_back('{S(1,1,1,2, 0,0,1),  E(1,0, 0,0,0,0,0,   1,7,3,192,0, 0)});
    tbl.push_back('{S(0,0,0,0, 0,0,0),  E(0,0, 1,288,1,1,2,  1,9,1,62,0,  0)});
    tbl.push_back('{S(0,0,0,0, 0,0,1),  E(0,0, 0,0,0,0,0,   1,9,1,62,0,  0)});
    tbl.push_back('{S(0,0,0,0, 1,11,1), E(0,1, 0,0,0,0,0,   0,0,0,0,0,   0)});
    tbl.push_back('{S(1,0,0,0, 0,0,1),  E(1,0, 0,0,0,0,0,   0,0,0,0,0,   0)});
    tbl.push_back('{S(1,0,1,3, 0,0,1),  E(1,0, 0,0,0,0,0,   0,0,0,0,0,   1)});
    tbl.push_back('{S(0,0,0,0, 0,0,1),  E(1,0, 0,0,0,0,0,   0,0,0,0,0,   2)});

    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    emptylist_out_valid = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].s, i);
      #1;
      chk($sformatf("row%0d", i), observe(), tbl[i].e);
      if (tbl[i].e.wr) chk($sformatf("row%0d_data", i), pkt_buffer_writedata.data, mkdata(i - 1));
    end

    // 40-flit packet on ID 11: flit 2 carries a stray SOP, flits 32..39 are dropped.
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      drive(S(k < 40, (k == 0 || k == 2), k == 39, (k == 39) ? 7 : 0, 0, 0, 1), 1000 + k);
      #1;
      if (k < 40) chk($sformatf("long%0d_rdy", k), {in_ready, meta_valid}, 2'b10);
      if (k >= 1 && k <= 32) begin
        chk($sformatf("long%0d_wr", k),
            {pkt_buffer_write, pkt_buffer_address, pkt_buffer_writedata.sop, pkt_buffer_writedata.eop},
            {1'b1, 17'((11 << 5) + k - 1), ((k - 1) == 0 || (k - 1) == 2), 1'b0});
        chk($sformatf("long%0d_data", k), pkt_buffer_writedata.data, mkdata(1000 + k - 1));
      end else if (k > 32) begin
        chk($sformatf("long%0d_nowr", k), pkt_buffer_write, 1'b0);
      end
    end
    chk("long_meta", {meta_valid, meta_pktID, meta_flits, meta_len, meta_trunc, err_cnt},
        {1'b1, 12'd11, 6'd32, 16'd2048, 1'b1, 16'd3});

    // Reset lands while packet on ID 20 is mid-flight.
    @(negedge clk);
    drive(S(0, 0, 0, 0, 1, 20, 1), 2000);
    #1 chk("rst_pop", emptylist_out_ready, 1'b1);
    @(negedge clk);
    drive(S(1, 1, 0, 0, 0, 0, 1), 2001);
    @(negedge clk);
    drive(S(1, 0, 0, 0, 0, 0, 1), 2002);
    #1 chk("rst_pre_wr", {pkt_buffer_write, pkt_buffer_address}, {1'b1, 17'd640});
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    drive(S(1, 0, 1, 0, 0, 0, 1), 2003);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("post_rst%0d", k), {in_ready, pkt_buffer_write, meta_valid}, 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
